// File: rtl/pipe_mem_access_ctrl.sv
// pipe_mem_access_ctrl: run/step/halt control that drains the pipeline and lends the I-Mem/D-Mem ports to a host for single accesses.
module pipe_mem_access_ctrl #(
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter int DMEM_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH     = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_en,
    input  logic                       step_req,
    input  logic                       host_req,
    input  logic                       host_rw,
    input  logic                       host_sel,
    input  logic [IMEM_ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]      host_wdata,
    output logic                       host_ack,
    output logic                       host_busy,
    output logic [DATA_WIDTH-1:0]      host_rdata,
    output logic                       pipe_fetch_en,
    output logic                       mem_owner,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0]     imem_din,
    input  logic [INSTR_WIDTH-1:0]     imem_dout,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_din,
    input  logic [DATA_WIDTH-1:0]      dmem_dout,
    output logic [31:0]                fetch_count
);
    typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_DRAIN, S_ACCESS, S_WAIT, S_ACK} state_t;
    state_t                     r_state, w_next;
    logic [3:0]                 r_drain_cnt;
    logic                       r_busy, r_rw, r_sel;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata, r_rdata;
    logic [31:0]                r_fetch_count;
    logic                       w_pending, w_latch, w_drain_done;
    assign w_latch      = host_req && !r_busy;
    assign w_pending    = r_busy || host_req;
    assign w_drain_done = r_drain_cnt == 4'(DRAIN_CYCLES - 1);
    always_comb begin
        w_next = S_HALT;
        case (r_state)
            S_HALT:   w_next = w_pending ? S_DRAIN : step_req ? S_STEP : run_en ? S_RUN : S_HALT;
            S_RUN:    w_next = w_pending ? S_DRAIN : run_en ? S_RUN : S_HALT;
            S_STEP:   w_next = S_HALT;
            S_DRAIN:  w_next = w_drain_done ? S_ACCESS : S_DRAIN;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   w_next = S_ACK;
            S_ACK:    w_next = run_en ? S_RUN : S_HALT;
            default:  w_next = S_HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_HALT;
            r_drain_cnt   <= '0;
            r_busy        <= 1'b0;
            r_rw          <= 1'b0;
            r_sel         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_next;
            r_drain_cnt   <= (r_state == S_DRAIN && !w_drain_done) ? r_drain_cnt + 4'd1 : 4'd0;
            r_fetch_count <= r_fetch_count + 32'(pipe_fetch_en);
            if (w_latch) begin
                r_busy  <= 1'b1;
                r_rw    <= host_rw;
                r_sel   <= host_sel;
                r_addr  <= host_addr;
                r_wdata <= host_wdata;
            end else if (r_state == S_WAIT) begin
                r_busy <= 1'b0;
            end
            // memories return read data one cycle after ACCESS presents the address
            if (r_state == S_WAIT && !r_rw)
                r_rdata <= r_sel ? dmem_dout : DATA_WIDTH'(imem_dout);
        end
    end
    assign pipe_fetch_en = r_state == S_RUN || r_state == S_STEP;
    assign mem_owner     = r_state == S_ACCESS || r_state == S_WAIT;
    assign imem_we       = r_state == S_ACCESS && r_rw && !r_sel;
    assign dmem_we       = r_state == S_ACCESS && r_rw && r_sel;
    assign imem_addr     = mem_owner ? r_addr : '0;
    assign dmem_addr     = mem_owner ? r_addr[DMEM_ADDR_WIDTH-1:0] : '0;
    assign imem_din      = mem_owner ? r_wdata[INSTR_WIDTH-1:0] : '0;
    assign dmem_din      = mem_owner ? r_wdata : '0;
    assign host_ack      = r_state == S_ACK;
    assign host_busy     = r_busy;
    assign host_rdata    = r_rdata;
    assign fetch_count   = r_fetch_count;
endmodule

// File: tb/tb_pipe_mem_access_ctrl.sv
// tb_pipe_mem_access_ctrl: randomized host/step/run stimulus checked against a transaction-level model.
module tb_pipe_mem_access_ctrl;
    localparam int D = 4;
    logic        clk = 1'b0;
    logic        reset, run_en, step_req, host_req, host_rw, host_sel;
    logic [8:0]  host_addr;
    logic [63:0] host_wdata, host_rdata, dmem_din, dmem_dout;
    logic        host_ack, host_busy, pipe_fetch_en, mem_owner, imem_we, dmem_we;
    logic [8:0]  imem_addr;
    logic [31:0] imem_din, imem_dout, fetch_count;
    logic [7:0]  dmem_addr;
    logic [31:0] imem_ram[512], exp_imem[512];
    logic [63:0] dmem_ram[256], exp_dmem[256];
    int          checks = 0, errors = 0;
    logic        running = 1'b0, stepping = 1'b0;
    logic [31:0] exp_cnt = 0;
    logic [63:0] last_rd = 0;
    always #5 clk = ~clk;
    pipe_mem_access_ctrl dut (
        .clk(clk), .reset(reset), .run_en(run_en), .step_req(step_req),
        .host_req(host_req), .host_rw(host_rw), .host_sel(host_sel),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_busy(host_busy), .host_rdata(host_rdata), .pipe_fetch_en(pipe_fetch_en),
        .mem_owner(mem_owner), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_din(imem_din), .imem_dout(imem_dout), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .fetch_count(fetch_count)
    );
    always @(posedge clk) begin
        if (imem_we) imem_ram[imem_addr] <= imem_din;
        if (dmem_we) dmem_ram[dmem_addr] <= dmem_din;
        imem_dout <= imem_ram[imem_addr];
        dmem_dout <= dmem_ram[dmem_addr];
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input logic step);
        logic f, nstep;
        step_req = step;
        f = running || stepping;
        chk("idle_fetch", pipe_fetch_en, f);
        chk("idle_owner", mem_owner, 0);
        chk("idle_we", {imem_we, dmem_we}, 0);
        chk("idle_ack", host_ack, 0);
        chk("idle_busy", host_busy, 0);
        exp_cnt += 32'(f);
        tick();
        nstep    = !running && !stepping && step;
        running  = !stepping && !nstep && run_en;
        stepping = nstep;
        step_req = 1'b0;
    endtask
    task automatic xact(input logic rw, input logic sel, input logic [8:0] addr,
                        input logic [63:0] wd, input logic step, input logic ren_final);
        logic [63:0] exp_rd;
        while (stepping) idle(1'b0);
        exp_rd = rw ? last_rd : sel ? exp_dmem[addr[7:0]] : {32'b0, exp_imem[addr]};
        host_req = 1'b1; host_rw = rw; host_sel = sel; host_addr = addr; host_wdata = wd;
        step_req = step;
        chk("req_fetch", pipe_fetch_en, running);
        chk("req_busy", host_busy, 0);
        exp_cnt += 32'(running);
        tick();
        for (int k = 1; k <= D + 3; k++) begin
            chk("x_fetch", pipe_fetch_en, 0);
            chk("x_owner", mem_owner, k == D + 1 || k == D + 2);
            chk("x_imem_we", imem_we, k == D + 1 && rw && !sel);
            chk("x_dmem_we", dmem_we, k == D + 1 && rw && sel);
            chk("x_ack", host_ack, k == D + 3);
            chk("x_busy", host_busy, k < D + 3);
            if (k == D + 1) begin
                chk("x_imem_addr", imem_addr, addr);
                chk("x_dmem_addr", dmem_addr, addr[7:0]);
                chk("x_imem_din", imem_din, wd[31:0]);
                chk("x_dmem_din", dmem_din, wd);
            end
            if (k == 1) chk("x_addr_idle", {imem_addr, dmem_addr, imem_din, dmem_din}, 0);
            if (k == D + 3) chk("x_rdata", host_rdata, exp_rd);
            if (k <= D + 2) begin
                host_req = 1'($urandom_range(0, 1)); host_rw = 1'($urandom_range(0, 1));
                host_sel = 1'($urandom_range(0, 1)); host_addr = 9'($urandom);
                host_wdata = {$urandom, $urandom}; step_req = 1'($urandom_range(0, 1));
                run_en = 1'($urandom_range(0, 1));
            end else begin
                host_req = 1'b0; step_req = 1'b0; run_en = ren_final;
            end
            tick();
        end
        running = ren_final;
        if (rw && sel) exp_dmem[addr[7:0]] = wd;
        else if (rw) exp_imem[addr] = wd[31:0];
        else last_rd = exp_rd;
        chk("x_fetch_count", fetch_count, exp_cnt);
    endtask
    initial begin
        logic [31:0] c0;
        int n;
        for (int i = 0; i < 512; i++) begin imem_ram[i] = $urandom; exp_imem[i] = imem_ram[i]; end
        for (int i = 0; i < 256; i++) begin dmem_ram[i] = {$urandom, $urandom}; exp_dmem[i] = dmem_ram[i]; end
        reset = 1'b0; run_en = 1'b1; step_req = 1'b1; host_req = 1'b1;
        host_rw = 1'b1; host_sel = 1'b1; host_addr = 9'h1AA; host_wdata = '1;
        repeat (3) tick();
        chk("rst_fetch", pipe_fetch_en, 0);
        chk("rst_owner", mem_owner, 0);
        chk("rst_busy", host_busy, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_we", {imem_we, dmem_we}, 0);
        chk("rst_addr", {imem_addr, dmem_addr, imem_din, dmem_din}, 0);
        reset = 1'b1; step_req = 1'b0; host_req = 1'b0;
        idle(1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("run10_count", fetch_count, 32'd10);
        xact(1'b1, 1'b1, 9'h105, 64'hDEADBEEF_01234567, 1'b0, 1'b1);
        idle(1'b0);
        chk("dmem_written", dmem_ram[8'h05], 64'hDEADBEEF_01234567);
        imem_ram[9'h1FF] = 32'h8A000000; exp_imem[9'h1FF] = 32'h8A000000;
        xact(1'b0, 1'b0, 9'h1FF, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("imem_rd_zext", host_rdata, 64'h00000000_8A000000);
        idle(1'b0); idle(1'b0);
        c0 = exp_cnt;
        for (int i = 0; i < 3; i++) begin idle(1'b1); idle(1'b0); idle(1'b0); end
        chk("step3_count", fetch_count, c0 + 3);
        c0 = exp_cnt;
        xact(1'b1, 1'b1, 9'h0F0, {$urandom, $urandom}, 1'b1, 1'b0);
        idle(1'b0);
        chk("step_drop_count", fetch_count, c0);
        for (int i = 0; i < 30; i++) begin
            run_en = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) idle(run_en ? 1'b0 : 1'($urandom_range(0, 1)));
            xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (stepping) idle(1'b0);
        host_req = 1'b1; host_rw = 1'b1; host_sel = 1'b1; host_addr = 9'h133;
        host_wdata = ~exp_dmem[8'h33];
        tick();
        host_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_fetch", pipe_fetch_en, 0);
        chk("mid_rst_owner", mem_owner, 0);
        chk("mid_rst_busy", host_busy, 0);
        chk("mid_rst_ack", host_ack, 0);
        chk("mid_rst_rdata", host_rdata, 0);
        chk("mid_rst_count", fetch_count, 0);
        chk("mid_rst_we", {imem_we, dmem_we}, 0);
        chk("mid_rst_addr", {imem_addr, dmem_addr, imem_din, dmem_din}, 0);
        reset = 1'b1; run_en = 1'b0;
        running = 1'b0; stepping = 1'b0; exp_cnt = 0;
        for (int i = 0; i < D + 6; i++) idle(1'b0);
        chk("mid_rst_no_write", dmem_ram[8'h33], exp_dmem[8'h33]);
        chk("mid_rst_rdata_after", host_rdata, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_mem_access_ctrl.md
PIPE_MEM_ACCESS_CTRL -- requirements
Module: pipe_mem_access_ctrl

Interface
REQ-001 SHALL have parameter IMEM_ADDR_WIDTH, default 9, I-Mem address width.
REQ-002 SHALL have parameter DMEM_ADDR_WIDTH, default 8, D-Mem address width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, D-Mem data width.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 4, pipeline drain length (legal range 1-15).
REQ-006 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port run_en  in  1  software run enable.
REQ-009 SHALL have port step_req  in  1  single-step pulse, honoured only while halted.
REQ-010 SHALL have port host_req  in  1  host memory access request.
REQ-011 SHALL have ports host_rw (in 1, 1=write), host_sel (in 1, 0=I-Mem, 1=D-Mem), host_addr (in IMEM_ADDR_WIDTH) and host_wdata (in DATA_WIDTH).
REQ-012 SHALL have ports host_ack (out 1, one-cycle completion pulse), host_busy (out 1) and host_rdata (out DATA_WIDTH).
REQ-013 SHALL have ports pipe_fetch_en (out 1, 0 = datapath injects NOP and holds PC) and mem_owner (out 1, 1 = host owns the memory ports).
REQ-014 SHALL have ports imem_we (out 1), imem_addr (out IMEM_ADDR_WIDTH), imem_din (out INSTR_WIDTH) and imem_dout (in INSTR_WIDTH).
REQ-015 SHALL have ports dmem_we (out 1), dmem_addr (out DMEM_ADDR_WIDTH), dmem_din (out DATA_WIDTH) and dmem_dout (in DATA_WIDTH).
REQ-016 SHALL have port fetch_count  out 32  number of cycles with pipe_fetch_en=1.

Function
REQ-017 SHALL implement the states HALT, RUN, STEP, DRAIN, ACCESS, WAIT and ACK.
REQ-018 SHALL behave in HALT as follows: fetch_en=0; host request pending -> DRAIN; else step_req -> STEP; else run_en=1 -> RUN.
REQ-019 SHALL behave in RUN as follows: fetch_en=1; host request pending -> DRAIN; else run_en=0 -> HALT.
REQ-020 SHALL assert fetch_en=1 for exactly one cycle in STEP, then go to HALT.
REQ-021 SHALL hold fetch_en=0 in DRAIN for exactly DRAIN_CYCLES cycles, then go to ACCESS.
REQ-022 SHALL drive the following in ACCESS (one cycle): mem_owner=1, addr from the latched request, and we=latched rw on the memory selected by host_sel only.
REQ-023 SHALL hold mem_owner=1 and we=0 in WAIT (one cycle), then capture the read data into host_rdata at the end of WAIT.
REQ-024 SHALL capture read data as follows: I-Mem reads zero-extend imem_dout to DATA_WIDTH; D-Mem reads load dmem_dout unchanged; writes leave host_rdata unchanged.
REQ-025 SHALL assert host_ack=1 for one cycle in ACK, with mem_owner=0, then go to RUN if run_en=1, else to HALT.
REQ-026 SHALL latch host_rw, host_sel, host_addr and host_wdata, and set host_busy=1, when host_req=1 and host_busy=0.
REQ-027 SHALL ignore host_req while host_busy=1.
REQ-028 SHALL clear host_busy in the ACK cycle.
REQ-029 SHALL give a latency of exactly DRAIN_CYCLES+3 cycles from the cycle host_req is sampled (in RUN or HALT) to host_ack.
REQ-030 SHALL, when a host request is latched during STEP, complete the step cycle first and then enter DRAIN through HALT with no extra step.
REQ-031 SHALL give a host request priority over step_req when both are present in HALT, and SHALL drop that step_req.
REQ-032 SHALL ignore step_req outside HALT.
REQ-033 SHALL drive D-Mem from host_addr[DMEM_ADDR_WIDTH-1:0], ignoring the upper bits.
REQ-034 SHALL drive I-Mem writes with host_wdata[INSTR_WIDTH-1:0].
REQ-035 SHALL hold imem_we and dmem_we at 0 in every state except ACCESS.
REQ-036 SHALL hold mem_owner at 0 outside ACCESS/WAIT.
REQ-037 SHALL hold imem_addr, dmem_addr, imem_din and dmem_din at the latched values while mem_owner=1, and at 0 otherwise.
REQ-038 SHALL increment fetch_count in every cycle with pipe_fetch_en=1, wrapping modulo 2^32.
REQ-039 SHALL ignore a change of run_en during DRAIN/ACCESS/WAIT until ACK.

Reset
REQ-040 SHALL apply the following when reset=0 at a rising edge: state=HALT, pipe_fetch_en=0, mem_owner=0, host_busy=0, host_ack=0, host_rdata=0, fetch_count=0, all we=0, all addr/din=0, drain counter=0.
REQ-041 SHALL, when reset occurs mid-access, abandon the pending request with no host_ack and no memory write after reset release.
REQ-042 SHALL take its first transition on the first edge with reset=1.

Verification
REQ-043 SHALL pass this bench case: reset, run_en=1, 10 cycles -> fetch_count=10, fetch_en=1 throughout, mem_owner=0.
REQ-044 SHALL pass this bench case: in RUN, write D-Mem addr 0x105, data 0xDEADBEEF_01234567 -> fetch_en=0 for 4 cycles, then dmem_we=1 for one cycle with dmem_addr=0x05, then host_ack 7 cycles after the request, then fetch_en=1 again.
REQ-045 SHALL pass this bench case: read I-Mem addr 0x1FF while the model returns 0x8A000000 -> host_rdata=0x00000000_8A000000 at host_ack, imem_we=0 throughout.
REQ-046 SHALL pass this bench case: in HALT, pulse step_req three times with a 2-cycle gap -> fetch_count=3, with each fetch_en pulse exactly 1 cycle wide.
REQ-047 SHALL pass this bench case: in HALT, step_req and host_req in the same cycle -> no STEP, host_ack after 7 cycles, fetch_count unchanged.
REQ-048 SHALL pass this bench case: D-Mem write request, then reset=0 during DRAIN cycle 2 -> no dmem_we pulse and no host_ack; all outputs at reset values.
